aes_key_sched: RTL and testbench

Iterative AES-128 key schedule. It sits directly upstream of aes_data_path and feeds it one round key per round over a valid/ready handshake. On a start pulse it latches the cipher key and emits round keys 0 through NUM_RND in order. Each round key is derived from the previous one with RotWord, SubWord and Rcon, with no precomputed key table.

---
 rtl/aes_key_sched.sv | 163 ++++++++++++++++
 tb/tb_aes_key_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_sched
//  Description : Iterative AES-128 key schedule. Latches the cipher key on a
//                start pulse and emits round keys 0..NUM_RND, one per accepted
//                valid/ready transfer, each derived from the previous key with
//                RotWord, SubWord and Rcon.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched #(
    parameter int RND_SIZE = 128,
    parameter int WRD_SIZE = 32,
    parameter int NUM_RND  = 10,
    parameter int CNT_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [RND_SIZE-1:0] i_key,
    input  logic                i_rnd_key_rdy,
    output logic [RND_SIZE-1:0] o_rnd_key,
    output logic                o_rnd_key_vld,
    output logic [CNT_SIZE-1:0] o_rnd_idx,
    output logic                o_busy,
    output logic                o_done
);

    // FIPS-197 forward S-box; element 0 sits at the most significant byte.
    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [CNT_SIZE-1:0] c_LAST_IDX = CNT_SIZE'(NUM_RND);
    localparam logic [7:0]          c_RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [RND_SIZE-1:0]   r_key;
    logic [CNT_SIZE-1:0]   r_idx;
    logic [7:0]            r_rcon;
    logic                  r_vld;
    logic                  r_busy;
    logic                  r_done;

    logic [WRD_SIZE-1:0]   w_w0, w_w1, w_w2, w_w3;
    logic [WRD_SIZE-1:0]   w_rot;
    logic [WRD_SIZE-1:0]   w_sub;
    logic [WRD_SIZE-1:0]   w_t;
    logic [WRD_SIZE-1:0]   w_n0, w_n1, w_n2, w_n3;
    logic [RND_SIZE-1:0]   w_next_key;
    logic [7:0]            w_rcon_next;
    logic                  w_xfer;

    assign w_w0 = r_key[4*WRD_SIZE-1:3*WRD_SIZE];
    assign w_w1 = r_key[3*WRD_SIZE-1:2*WRD_SIZE];
    assign w_w2 = r_key[2*WRD_SIZE-1:WRD_SIZE];
    assign w_w3 = r_key[WRD_SIZE-1:0];

    // RotWord: top byte moves to the bottom.
    assign w_rot = {w_w3[WRD_SIZE-9:0], w_w3[WRD_SIZE-1:WRD_SIZE-8]};

    // SubWord: one S-box lookup per byte lane.
    generate
        for (genvar g = 0; g < WRD_SIZE/8; g++) begin : g_sbox
            assign w_sub[8*g +: 8] = c_SBOX[w_rot[8*g +: 8]];
        end
    endgenerate

    assign w_t  = w_sub ^ {r_rcon, {(WRD_SIZE-8){1'b0}}};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    // xtime in GF(2^8) with the AES reduction polynomial.
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    assign w_xfer = r_vld & i_rnd_key_rdy;

    // Control FSM with all outputs registered; key/idx/rcon only move on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_rcon  <= c_RCON_INIT;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_key   <= i_key;
                        r_idx   <= '0;
                        r_rcon  <= c_RCON_INIT;
                        r_vld   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_EMIT;
                    end else begin
                        r_vld  <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                S_EMIT: begin
                    if (w_xfer) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_vld   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_key  <= w_next_key;
                            r_idx  <= r_idx + 1'b1;
                            r_rcon <= w_rcon_next;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_vld   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rnd_key     = r_key;
    assign o_rnd_key_vld = r_vld;
    assign o_rnd_idx     = r_idx;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_sched
//  Description : Self-checking bench for aes_key_sched. Reference schedule is
//                built from the FIPS-197 word-wise key expansion using an
//                S-box derived from GF(2^8) inversion plus the affine map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [127:0] i_key;
    logic         i_rnd_key_rdy;
    logic [127:0] o_rnd_key;
    logic         o_rnd_key_vld;
    logic [3:0]   o_rnd_idx;
    logic         o_busy;
    logic         o_done;

    aes_key_sched #(
        .RND_SIZE (128),
        .WRD_SIZE (32),
        .NUM_RND  (10),
        .CNT_SIZE (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_key         (i_key),
        .i_rnd_key_rdy (i_rnd_key_rdy),
        .o_rnd_key     (o_rnd_key),
        .o_rnd_key_vld (o_rnd_key_vld),
        .o_rnd_idx     (o_rnd_idx),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int done_cnt = 0;

    logic [7:0]   sb [256];
    logic [127:0] model [11];
    logic [127:0] q_key [$];
    logic [3:0]   q_idx [$];

    logic         prev_stall = 1'b0;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;

    localparam logic [127:0] c_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        logic [127:0] key;
        logic [127:0] exp1;
        logic [127:0] exp10;
    } vec_t;

    vec_t tab [3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Standard word-indexed key expansion w[0..43].
    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always @(posedge clk) cyc++;

    // Transfer capture, done counting and hold-stable-under-backpressure check.
    always @(negedge clk) begin
        if (!rst && o_rnd_key_vld && i_rnd_key_rdy) begin
            q_key.push_back(o_rnd_key);
            q_idx.push_back(o_rnd_idx);
        end
        if (o_done) done_cnt++;
        if (prev_stall && o_rnd_key_vld && !rst) begin
            chk("stall_key", o_rnd_key, prev_key);
            chk("stall_idx", 128'(o_rnd_idx), 128'(prev_idx));
        end
        prev_stall = o_rnd_key_vld && !i_rnd_key_rdy && !rst;
        prev_key   = o_rnd_key;
        prev_idx   = o_rnd_idx;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full schedule; bp randomises ready, ign fires a stray start at idx 3.
    task automatic run_sched(input logic [127:0] key, input bit bp, input bit ign);
        int  t0;
        bit  seen_done;
        bit  ign_done;
        compute_model(key);
        q_key.delete();
        q_idx.delete();
        step();
        chk("idle_busy", 128'(o_busy), 128'(0));
        chk("idle_done", 128'(o_done), 128'(0));
        i_start = 1'b1;
        i_key   = key;
        i_rnd_key_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        t0 = cyc;
        step();
        i_start = 1'b0;
        i_key   = {$urandom, $urandom, $urandom, $urandom};
        chk("lat1_vld", 128'(o_rnd_key_vld), 128'(1));
        seen_done = 1'b0;
        ign_done  = 1'b0;
        for (int n = 0; n < 300 && !seen_done; n++) begin
            if (ign && !ign_done && o_rnd_idx == 4'd3) begin
                i_start  = 1'b1;
                i_key    = c_SEQ;
                ign_done = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            i_rnd_key_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            if (o_done) seen_done = 1'b1;
        end
        i_start = 1'b0;
        chk("done_seen", 128'(seen_done), 128'(1));
        if (!bp && !ign) chk("done_latency", 128'(cyc - t0), 128'(12));
        chk("done_busy", 128'(o_busy), 128'(1));
        chk("done_vld", 128'(o_rnd_key_vld), 128'(0));
        chk("xfer_count", 128'(q_key.size()), 128'(11));
        for (int i = 0; i < q_key.size() && i < 11; i++) begin
            chk($sformatf("key_r%0d", i), q_key[i], model[i]);
            chk($sformatf("idx_r%0d", i), 128'(q_idx[i]), 128'(i));
        end
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        i_start = 1'b0;
        i_key = '0;
        i_rnd_key_rdy = 1'b0;
        build_sbox();

        tab[0] = '{c_FIPS, 128'ha0fafe1788542cb123a339392a6c7605,
                           128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tab[1] = '{c_SEQ,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                           128'h13111d7fe3944a17f307a78b4d2b30c5};
        tab[2] = '{128'h0, 128'h62636363626363636263636362636363,
                           128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        step(); step();
        rst = 1'b0;
        chk("rst_key",  o_rnd_key, 128'h0);
        chk("rst_vld",  128'(o_rnd_key_vld), 128'(0));
        chk("rst_idx",  128'(o_rnd_idx), 128'(0));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_done", 128'(o_done), 128'(0));

        // Known-answer table; entries run back to back (start right after done).
        for (int v = 0; v < 3; v++) begin
            run_sched(tab[v].key, 1'b0, 1'b0);
            if (q_key.size() == 11) begin
                chk($sformatf("tab%0d_idx0", v),  q_key[0],  tab[v].key);
                chk($sformatf("tab%0d_idx1", v),  q_key[1],  tab[v].exp1);
                chk($sformatf("tab%0d_idx10", v), q_key[10], tab[v].exp10);
            end
        end

        // Backpressure and ignored start on the FIPS key.
        run_sched(c_FIPS, 1'b1, 1'b0);
        run_sched(c_FIPS, 1'b0, 1'b1);
        if (q_key.size() == 11) chk("ign_idx10", q_key[10], tab[0].exp10);

        // Reset mid-schedule at idx 4.
        step();
        i_start = 1'b1;
        i_key   = c_FIPS;
        step();
        i_start = 1'b0;
        i_rnd_key_rdy = 1'b1;
        for (int k = 0; k < 50 && o_rnd_idx != 4'd4; k++) step();
        chk("abort_at_idx4", 128'(o_rnd_idx), 128'(4));
        d0 = done_cnt;
        rst = 1'b1;
        step();
        chk("abort_key",  o_rnd_key, 128'h0);
        chk("abort_vld",  128'(o_rnd_key_vld), 128'(0));
        chk("abort_idx",  128'(o_rnd_idx), 128'(0));
        chk("abort_busy", 128'(o_busy), 128'(0));
        chk("abort_done", 128'(o_done), 128'(0));
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 15; k++) step();
        chk("abort_no_done", 128'(done_cnt), 128'(d0));
        run_sched(c_SEQ, 1'b0, 1'b0);

        // Random keys with random backpressure.
        for (int r = 0; r < 4; r++)
            run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);

        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
